// File: rtl/wb_stage_if.sv
// MEM->WB bundle and register-file write / forwarding bus.
// The MEM stage side is the master; wb_stage is the slave.
interface wb_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
);
  logic            mem_valid;
  logic            mem_flush;
  logic            mem_regwrite;
  logic [4:0]      mem_rd;
  logic [1:0]      mem_wb_sel;
  logic [2:0]      mem_funct3;
  logic [1:0]      mem_addr_lo;
  logic [XLEN-1:0] mem_alu_result;
  logic [XLEN-1:0] mem_load_data;
  logic [XLEN-1:0] mem_pc_plus4;

  logic            regwrite;
  logic [4:0]      write_reg;
  logic [XLEN-1:0] write_data;
  logic            fwd_valid;
  logic [4:0]      fwd_rd;
  logic [XLEN-1:0] fwd_data;
  logic            misalign_err;
  logic [CNT_W-1:0] instret;

  modport master (
    output mem_valid, mem_flush, mem_regwrite,
    output mem_rd, mem_wb_sel, mem_funct3,
    output mem_addr_lo, mem_alu_result,
    output mem_load_data, mem_pc_plus4,
    input  regwrite, write_reg, write_data,
    input  fwd_valid, fwd_rd, fwd_data,
    input  misalign_err, instret
  );

  modport slave (
    input  mem_valid, mem_flush, mem_regwrite,
    input  mem_rd, mem_wb_sel, mem_funct3,
    input  mem_addr_lo, mem_alu_result,
    input  mem_load_data, mem_pc_plus4,
    output regwrite, write_reg, write_data,
    output fwd_valid, fwd_rd, fwd_data,
    output misalign_err, instret
  );
endinterface

// File: rtl/wb_stage.sv
// MEM/WB pipeline register, load extension and writeback port.
// Also counts retired instructions (illegal loads excluded).
module wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input logic         clock,
  input logic         reset,
  wb_stage_if.slave   bus
);
  logic             wb_valid_q, wb_valid_d;
  logic             wb_regwrite_q;
  logic [4:0]       wb_rd_q;
  logic [1:0]       wb_sel_q;
  logic [2:0]       wb_f3_q;
  logic [1:0]       wb_lo_q;
  logic [XLEN-1:0]  wb_alu_q;
  logic [XLEN-1:0]  wb_ld_q;
  logic [XLEN-1:0]  wb_pc4_q;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic             take;
  logic             is_load;
  logic             load_err;
  logic [7:0]       lane_b;
  logic [15:0]      lane_h;
  logic [XLEN-1:0]  load_val;
  logic [XLEN-1:0]  res;
  logic             rw;

  // flush beats valid; fields hold while a bubble is captured
  assign take       = bus.mem_valid & ~bus.mem_flush;
  assign wb_valid_d = take;
  assign is_load    = (wb_sel_q == 2'b01);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_valid_q    <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_rd_q       <= '0;
      wb_sel_q      <= '0;
      wb_f3_q       <= '0;
      wb_lo_q       <= '0;
      wb_alu_q      <= '0;
      wb_ld_q       <= '0;
      wb_pc4_q      <= '0;
      instret_q     <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      instret_q  <= instret_d;
      if (take) begin
        wb_regwrite_q <= bus.mem_regwrite;
        wb_rd_q       <= bus.mem_rd;
        wb_sel_q      <= bus.mem_wb_sel;
        wb_f3_q       <= bus.mem_funct3;
        wb_lo_q       <= bus.mem_addr_lo;
        wb_alu_q      <= bus.mem_alu_result;
        wb_ld_q       <= bus.mem_load_data;
        wb_pc4_q      <= bus.mem_pc_plus4;
      end
    end
  end

  always_comb begin
    lane_b = wb_ld_q[7:0];
    unique case (wb_lo_q)
      2'd0: lane_b = wb_ld_q[7:0];
      2'd1: lane_b = wb_ld_q[15:8];
      2'd2: lane_b = wb_ld_q[23:16];
      2'd3: lane_b = wb_ld_q[31:24];
    endcase
    lane_h = wb_lo_q[1] ? wb_ld_q[31:16] : wb_ld_q[15:0];
  end

  always_comb begin
    load_val = '0;
    load_err = 1'b0;
    unique case (wb_f3_q)
      3'b000: load_val = {{(XLEN-8){lane_b[7]}}, lane_b};
      3'b100: load_val = {{(XLEN-8){1'b0}}, lane_b};
      3'b001: begin
        load_val = {{(XLEN-16){lane_h[15]}}, lane_h};
        load_err = wb_lo_q[0];
      end
      3'b101: begin
        load_val = {{(XLEN-16){1'b0}}, lane_h};
        load_err = wb_lo_q[0];
      end
      3'b010: begin
        load_val = wb_ld_q;
        load_err = |wb_lo_q;
      end
      default: load_err = 1'b1;
    endcase
    if (!is_load) load_err = 1'b0;
  end

  always_comb begin
    res = '0;
    unique case (1'b1)
      (wb_sel_q == 2'b00): res = wb_alu_q;
      (wb_sel_q == 2'b01): res = load_val;
      (wb_sel_q == 2'b10): res = wb_pc4_q;
      default:             res = '0;
    endcase
  end

  assign rw = wb_valid_q & wb_regwrite_q & (|wb_rd_q)
            & (wb_sel_q != 2'b11) & ~load_err;

  // stores and branches retire too, so regwrite is not part of this
  assign instret_d = instret_q
                   + CNT_W'(wb_valid_q & ~load_err);

  assign bus.regwrite     = rw;
  assign bus.write_reg    = rw ? wb_rd_q : 5'd0;
  assign bus.write_data   = rw ? res : '0;
  assign bus.fwd_valid    = rw;
  assign bus.fwd_rd       = rw ? wb_rd_q : 5'd0;
  assign bus.fwd_data     = rw ? res : '0;
  assign bus.misalign_err = wb_valid_q & load_err;
  assign bus.instret      = instret_q;
endmodule

// File: tb/tb_wb_stage.sv
// Directed + random bench for wb_stage.
// A second, narrow-counter instance exercises instret wrap.
module tb_wb_stage;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  wb_stage_if #(.XLEN(32), .CNT_W(64)) ifc ();
  wb_stage_if #(.XLEN(32), .CNT_W(4))  ifw ();

  wb_stage #(.XLEN(32), .CNT_W(64)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc.slave)
  );

  wb_stage #(.XLEN(32), .CNT_W(4)) dut_w (
    .clock (clock),
    .reset (reset),
    .bus   (ifw.slave)
  );

  assign ifw.mem_valid      = ifc.mem_valid;
  assign ifw.mem_flush      = ifc.mem_flush;
  assign ifw.mem_regwrite   = ifc.mem_regwrite;
  assign ifw.mem_rd         = ifc.mem_rd;
  assign ifw.mem_wb_sel     = ifc.mem_wb_sel;
  assign ifw.mem_funct3     = ifc.mem_funct3;
  assign ifw.mem_addr_lo    = ifc.mem_addr_lo;
  assign ifw.mem_alu_result = ifc.mem_alu_result;
  assign ifw.mem_load_data  = ifc.mem_load_data;
  assign ifw.mem_pc_plus4   = ifc.mem_pc_plus4;

  typedef struct packed {
    logic        valid;
    logic        flush;
    logic        regwrite;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] alu;
    logic [31:0] ld;
    logic [31:0] pc4;
  } tx_t;

  int n_cmp = 0;
  int n_bad = 0;
  tx_t cur;
  logic [63:0] cnt;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // What the write port should show for the instruction held in WB
  function automatic void model(input tx_t t, output logic rw,
                                output logic err,
                                output logic [31:0] d);
    int unsigned b, h;
    b = (t.ld >> (8 * int'(t.lo))) & 32'hFF;
    h = (t.ld >> (16 * (int'(t.lo) / 2))) & 32'hFFFF;
    err = 1'b0;
    d = 32'd0;
    if (t.sel == 2'd1) begin
      case (t.f3)
        3'd0: d = (b >= 128) ? b + 32'hFFFFFF00 : b;
        3'd4: d = b;
        3'd1: begin
          d = (h >= 32768) ? h + 32'hFFFF0000 : h;
          err = (t.lo % 2) != 0;
        end
        3'd5: begin
          d = h;
          err = (t.lo % 2) != 0;
        end
        3'd2: begin
          d = t.ld;
          err = t.lo != 0;
        end
        default: err = 1'b1;
      endcase
    end else if (t.sel == 2'd0) d = t.alu;
    else if (t.sel == 2'd2) d = t.pc4;
    rw = t.valid && t.regwrite && t.rd != 0 && t.sel != 3 && !err;
    if (!rw) d = 32'd0;
  endfunction

  task automatic check_out();
    logic rw, err;
    logic [31:0] d;
    model(cur, rw, err, d);
    chk("regwrite", 64'(ifc.regwrite), 64'(rw));
    chk("write_reg", 64'(ifc.write_reg), rw ? 64'(cur.rd) : 64'd0);
    chk("write_data", 64'(ifc.write_data), 64'(d));
    chk("fwd_valid", 64'(ifc.fwd_valid), 64'(rw));
    chk("fwd_rd", 64'(ifc.fwd_rd), rw ? 64'(cur.rd) : 64'd0);
    chk("fwd_data", 64'(ifc.fwd_data), 64'(d));
    chk("misalign", 64'(ifc.misalign_err), 64'(cur.valid && err));
    chk("instret", ifc.instret, cnt);
    chk("instret_w", 64'(ifw.instret), 64'(cnt[3:0]));
  endtask

  // Called just after a negedge; returns just after the next negedge
  task automatic cyc(input tx_t t);
    logic rw, err;
    logic [31:0] d;
    ifc.mem_valid      = t.valid;
    ifc.mem_flush      = t.flush;
    ifc.mem_regwrite   = t.regwrite;
    ifc.mem_rd         = t.rd;
    ifc.mem_wb_sel     = t.sel;
    ifc.mem_funct3     = t.f3;
    ifc.mem_addr_lo    = t.lo;
    ifc.mem_alu_result = t.alu;
    ifc.mem_load_data  = t.ld;
    ifc.mem_pc_plus4   = t.pc4;
    @(posedge clock);
    model(cur, rw, err, d);
    if (cur.valid && !err) cnt = cnt + 64'd1;
    if (t.valid && !t.flush) cur = t;
    else cur.valid = 1'b0;
    #1;
    check_out();
    @(negedge clock);
  endtask

  function automatic tx_t mk(input logic [1:0] sel, input logic [4:0] rd,
                             input logic [2:0] f3, input logic [1:0] lo,
                             input logic [31:0] v);
    tx_t t;
    t = '0;
    t.valid = 1'b1;
    t.regwrite = 1'b1;
    t.rd = rd;
    t.sel = sel;
    t.f3 = f3;
    t.lo = lo;
    t.alu = v;
    t.ld = v;
    t.pc4 = v;
    return t;
  endfunction

  task automatic idle();
    tx_t t;
    t = '0;
    cyc(t);
  endtask

  tx_t t;
  logic [31:0] w;

  initial begin
    cur = '0;
    cnt = 64'd0;
    t = '0;
    ifc.mem_valid = 1'b0;
    ifc.mem_flush = 1'b0;
    ifc.mem_regwrite = 1'b0;
    ifc.mem_rd = '0;
    ifc.mem_wb_sel = '0;
    ifc.mem_funct3 = '0;
    ifc.mem_addr_lo = '0;
    ifc.mem_alu_result = '0;
    ifc.mem_load_data = '0;
    ifc.mem_pc_plus4 = '0;

    #1;
    chk("rst_regwrite", 64'(ifc.regwrite), 64'd0);
    chk("rst_data", 64'(ifc.write_data), 64'd0);
    chk("rst_instret", ifc.instret, 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_out();

    // ALU write then instret step on the following edge
    cyc(mk(2'd0, 5'd5, 3'd0, 2'd0, 32'hDEADBEEF));
    chk("t1_data", 64'(ifc.write_data), 64'hDEADBEEF);
    chk("t1_reg", 64'(ifc.write_reg), 64'd5);
    idle();
    chk("t1_instret", ifc.instret, 64'd1);

    // byte loads across all lanes, back to back
    for (int i = 0; i < 4; i++) cyc(mk(2'd1, 5'd7, 3'd0, 2'(i), 32'h80FF7F01));
    for (int i = 0; i < 4; i++) cyc(mk(2'd1, 5'd8, 3'd4, 2'(i), 32'h80FF7F01));
    chk("t2_lbu3", 64'(ifc.write_data), 64'h80);

    cyc(mk(2'd1, 5'd9, 3'd1, 2'd2, 32'h80011234));
    chk("t3_lh", 64'(ifc.write_data), 64'hFFFF8001);
    for (int f = 0; f < 8; f++)
      for (int lo = 0; lo < 4; lo++)
        cyc(mk(2'd1, 5'd10, 3'(f), 2'(lo), 32'h8001F234));
    cyc(mk(2'd1, 5'd11, 3'd2, 2'd1, 32'h12345678));
    chk("t3_mis", 64'(ifc.misalign_err), 64'd1);
    idle();

    cyc(mk(2'd2, 5'd1, 3'd0, 2'd0, 32'h104));
    chk("t4_jal", 64'(ifc.write_data), 64'h104);
    cyc(mk(2'd0, 5'd0, 3'd0, 2'd0, 32'h55));
    cyc(mk(2'd3, 5'd3, 3'd0, 2'd0, 32'h66));

    t = mk(2'd0, 5'd4, 3'd0, 2'd0, 32'h77);
    t.flush = 1'b1;
    cyc(t);
    idle();

    // async reset with a write pending in WB
    cyc(mk(2'd0, 5'd6, 3'd0, 2'd0, 32'hCAFE0001));
    ifc.mem_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("t5_rw", 64'(ifc.regwrite), 64'd0);
    chk("t5_data", 64'(ifc.write_data), 64'd0);
    chk("t5_instret", ifc.instret, 64'd0);
    cur = '0;
    cnt = 64'd0;
    @(negedge clock);
    reset = 1'b0;
    idle();

    // narrow counter wraps after 16 retirements
    for (int i = 0; i < 16; i++) cyc(mk(2'd0, 5'(i), 3'd0, 2'd0, 32'(i)));
    idle();
    chk("t6_wrap", 64'(ifw.instret), 64'd0);
    chk("t6_cnt", ifc.instret, 64'd16);

    for (int i = 0; i < 400; i++) begin
      w = $urandom;
      t = '0;
      t.valid = ($urandom % 4) != 0;
      t.flush = ($urandom % 8) == 0;
      t.regwrite = ($urandom % 5) != 0;
      t.rd = 5'($urandom);
      t.sel = 2'($urandom);
      t.f3 = 3'($urandom);
      t.lo = 2'($urandom);
      t.alu = $urandom;
      t.ld = w;
      t.pc4 = $urandom;
      cyc(t);
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
